// File: rtl/inst_fetch_responder.sv
// Fetch-side responder: issues fetch requests in order to the instruction memory/MMU port
// and returns the read data to fetch in request order, dropping responses killed by a flush.
//
// state | meaning
// IDLE  | issue register empty, memory port idle
// ISSUE | issue register holds a request, oMEM_REQ asserted until memory takes it
module inst_fetch_responder #(
   parameter int DEPTH   = 4,
   parameter int DEPTH_N = 2
) (
   input  logic        iCLOCK,
   input  logic        iRESET_SYNC,
   input  logic        iFLUSH,
   input  logic        iFETCH_REQ,
   output logic        oFETCH_LOCK,
   input  logic [1:0]  iFETCH_MMUMOD,
   input  logic [2:0]  iFETCH_MMUPS,
   input  logic [13:0] iFETCH_ASID,
   input  logic [31:0] iFETCH_PDT,
   input  logic [31:0] iFETCH_ADDR,
   output logic        oINST_VALID,
   output logic [31:0] oINST,
   output logic [11:0] oMMU_FLAGS,
   input  logic        iINST_LOCK,
   output logic        oMEM_REQ,
   input  logic        iMEM_LOCK,
   output logic [31:0] oMEM_ADDR,
   output logic [1:0]  oMEM_MMUMOD,
   output logic [2:0]  oMEM_MMUPS,
   output logic [13:0] oMEM_ASID,
   output logic [31:0] oMEM_PDT,
   input  logic        iMEM_VALID,
   input  logic [31:0] iMEM_DATA,
   input  logic [11:0] iMEM_MMU_FLAGS
);

   typedef enum logic {IDLE, ISSUE} state_t;

   localparam logic [DEPTH_N:0]   CNT_ONE  = (DEPTH_N+1)'(1);
   localparam logic [DEPTH_N:0]   CNT_FULL = (DEPTH_N+1)'(DEPTH);
   localparam logic [DEPTH_N-1:0] PTR_ONE  = DEPTH_N'(1);

   state_t             state_q;
   logic [31:0]        addr_q, pdt_q;
   logic [1:0]         mmumod_q;
   logic [2:0]         mmups_q;
   logic [13:0]        asid_q;
   logic [DEPTH_N:0]   inflight_q, inflight_d, discard_q, discard_d, count_q, count_d, total;
   logic [DEPTH_N-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [43:0]        fifo_mem [DEPTH];
   logic               occ, accept, handoff, rsp_ok, push, pop;

   assign occ     = (state_q == ISSUE);
   assign total   = {{DEPTH_N{1'b0}}, occ} + inflight_q + count_q;
   assign handoff = occ && !iMEM_LOCK;
   assign rsp_ok  = iMEM_VALID && (inflight_q != '0);
   assign pop     = (count_q != '0) && !iINST_LOCK && !iFLUSH;
   assign push    = rsp_ok && (discard_q == '0) && !iFLUSH;
   assign accept  = iFETCH_REQ && !oFETCH_LOCK;

   assign oFETCH_LOCK = (total == CNT_FULL) || (occ && iMEM_LOCK) || iFLUSH;
   assign oINST_VALID = pop;
   assign {oINST, oMMU_FLAGS} = (count_q != '0) ? fifo_mem[rd_ptr_q] : '0;

   assign oMEM_REQ    = occ;
   assign oMEM_ADDR   = addr_q;
   assign oMEM_MMUMOD = mmumod_q;
   assign oMEM_MMUPS  = mmups_q;
   assign oMEM_ASID   = asid_q;
   assign oMEM_PDT    = pdt_q;

   // A new accept while in ISSUE only happens together with a handoff, so loading always wins.
   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         mmumod_q <= '0;
         mmups_q  <= '0;
         asid_q   <= '0;
         pdt_q    <= '0;
      end else if (iFLUSH) begin
         state_q <= IDLE;
      end else if (accept) begin
         state_q  <= ISSUE;
         addr_q   <= {iFETCH_ADDR[31:2], 2'b00};
         mmumod_q <= iFETCH_MMUMOD;
         mmups_q  <= iFETCH_MMUPS;
         asid_q   <= iFETCH_ASID;
         pdt_q    <= iFETCH_PDT;
      end else if (handoff) begin
         state_q <= IDLE;
      end
   end

   always_comb begin
      inflight_d = inflight_q;
      discard_d  = discard_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      if (handoff) inflight_d = inflight_d + CNT_ONE;
      if (rsp_ok)  inflight_d = inflight_d - CNT_ONE;
      if (iFLUSH) begin
         // everything still out at memory after this cycle belongs to the flushed stream
         discard_d = inflight_d;
         count_d   = '0;
         rd_ptr_d  = '0;
         wr_ptr_d  = '0;
      end else begin
         if (rsp_ok && (discard_q != '0)) discard_d = discard_q - CNT_ONE;
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            count_d  = count_d + CNT_ONE;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            count_d  = count_d - CNT_ONE;
         end
      end
   end

   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         inflight_q <= '0;
         discard_q  <= '0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   always_ff @(posedge iCLOCK) begin
      if (push) fifo_mem[wr_ptr_q] <= {iMEM_DATA, iMEM_MMU_FLAGS};
   end

endmodule
